pipelined_cla_subtractor_16bit: RTL and testbench

PIPELINED_CLA_SUBTRACTOR_16BIT -- requirements
Module: pipelined_cla_subtractor_16bit

---
 rtl/pipelined_cla_subtractor_16bit.sv | 162 ++++++++++++++++
 tb/tb_pipelined_cla_subtractor_16bit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_subtractor_16bit.sv
// 16-bit subtractor D = X - Y - Bin built as X + ~Y + ~Bin on a two-level
// carry-lookahead network, split over a 2-stage valid/ready pipeline.
// Stage 1 holds per-bit propagate/generate and group Gstar/Pstar; stage 2
// resolves the top-level carries and holds D, Bout, V, Z.
module pipelined_cla_subtractor_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic        Bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] D,
    output logic        Bout,
    output logic        V,
    output logic        Z
);

    // Stage 1 state
    logic        s1_valid_q;
    logic [15:0] p_q;
    logic [14:0] g_q;       // bit-15 generate is rebuilt from the operand MSBs
    logic [3:0]  gs_q;
    logic [3:0]  ps_q;
    logic        c0_q;
    logic        x15_q;
    logic        ny15_q;

    // Stage 2 state
    logic        s2_valid_q;
    logic [15:0] d_q;
    logic        bout_q;
    logic        v_q;
    logic        z_q;

    // Stage 1 next-state values
    logic [15:0] ny_d;
    logic [15:0] p_d;
    logic [15:0] g_d;
    logic [3:0]  gs_d;
    logic [3:0]  ps_d;
    logic [3:0]  gg1;
    logic [3:0]  pp1;

    // Stage 2 next-state values
    logic [15:0] g_full;
    logic [4:0]  gc;
    logic [16:0] c;
    logic [3:0]  gg2;
    logic [3:0]  pp2;
    logic        cin;
    logic [15:0] d_d;
    logic        bout_d;
    logic        v_d;
    logic        z_d;

    // Handshake: stage 2 drains when empty or taken; stage 1 when empty or stage 2 drains
    logic adv2;
    logic adv1;
    assign adv2      = !s2_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign D         = d_q;
    assign Bout      = bout_q;
    assign V         = v_q;
    assign Z         = z_q;

    // Per-bit G/P of X + ~Y and 4-bit group Gstar/Pstar
    always_comb begin
        ny_d = ~Y;
        p_d  = X ^ ny_d;
        g_d  = X & ny_d;
        gs_d = '0;
        ps_d = '0;
        gg1  = '0;
        pp1  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            gg1     = g_d[4*k +: 4];
            pp1     = p_d[4*k +: 4];
            gs_d[k] = gg1[3] | (pp1[3] & gg1[2]) | (pp1[3] & pp1[2] & gg1[1])
                    | (pp1[3] & pp1[2] & pp1[1] & gg1[0]);
            ps_d[k] = &pp1;
        end
    end

    // Top-level lookahead for C4..C16, then in-group lookahead and sum/flags
    always_comb begin
        g_full = {x15_q & ny15_q, g_q};
        gc[0]  = c0_q;
        gc[1]  = gs_q[0] | (ps_q[0] & c0_q);
        gc[2]  = gs_q[1] | (ps_q[1] & gs_q[0]) | (ps_q[1] & ps_q[0] & c0_q);
        gc[3]  = gs_q[2] | (ps_q[2] & gs_q[1]) | (ps_q[2] & ps_q[1] & gs_q[0])
               | (ps_q[2] & ps_q[1] & ps_q[0] & c0_q);
        gc[4]  = gs_q[3] | (ps_q[3] & gs_q[2]) | (ps_q[3] & ps_q[2] & gs_q[1])
               | (ps_q[3] & ps_q[2] & ps_q[1] & gs_q[0])
               | (ps_q[3] & ps_q[2] & ps_q[1] & ps_q[0] & c0_q);
        c   = '0;
        gg2 = '0;
        pp2 = '0;
        cin = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            gg2          = g_full[4*k +: 4];
            pp2          = p_q[4*k +: 4];
            cin          = gc[k];
            c[4*k]       = cin;
            c[4*k + 1]   = gg2[0] | (pp2[0] & cin);
            c[4*k + 2]   = gg2[1] | (pp2[1] & gg2[0]) | (pp2[1] & pp2[0] & cin);
            c[4*k + 3]   = gg2[2] | (pp2[2] & gg2[1]) | (pp2[2] & pp2[1] & gg2[0])
                         | (pp2[2] & pp2[1] & pp2[0] & cin);
        end
        c[16]  = gc[4];
        d_d    = p_q ^ c[15:0];
        bout_d = ~c[16];
        v_d    = c[16] ^ c[15];
        z_d    = (d_d == '0);
    end

    // Pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            gs_q       <= '0;
            ps_q       <= '0;
            c0_q       <= 1'b0;
            x15_q      <= 1'b0;
            ny15_q     <= 1'b0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            bout_q     <= 1'b0;
            v_q        <= 1'b0;
            z_q        <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    p_q    <= p_d;
                    g_q    <= g_d[14:0];
                    gs_q   <= gs_d;
                    ps_q   <= ps_d;
                    c0_q   <= ~Bin;
                    x15_q  <= X[15];
                    ny15_q <= ny_d[15];
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    d_q    <= d_d;
                    bout_q <= bout_d;
                    v_q    <= v_d;
                    z_q    <= z_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_subtractor_16bit.sv
// Directed bench for the pipelined 16-bit CLA subtractor: reset values,
// single-vector latency and flags, back-to-back flow with a stall, and
// mid-operation reset.
module tb_pipelined_cla_subtractor_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X;
    logic [15:0] Y;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        Bout;
    logic        V;
    logic        Z;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipelined_cla_subtractor_16bit u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .Bout      (Bout),
        .V         (V),
        .Z         (Z)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Starts and ends at a falling edge; exp packs {D, Bout, V, Z}
    task automatic one_vec(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic b, input logic [18:0] exp);
        X         = x;
        Y         = y;
        Bin       = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_pre"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);          // accept edge: operands enter stage 1
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_mid"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);          // result moves into stage 2
        @(negedge clk);
        chk({tag, "_ov"},   {31'd0, out_valid}, 32'd1);
        chk({tag, "_D"},    {16'd0, D},         {16'd0, exp[18:3]});
        chk({tag, "_Bout"}, {31'd0, Bout},      {31'd0, exp[2]});
        chk({tag, "_V"},    {31'd0, V},         {31'd0, exp[1]});
        chk({tag, "_Z"},    {31'd0, Z},         {31'd0, exp[0]});
        @(posedge clk);          // consumed with out_ready=1
        @(negedge clk);
        chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [15:0] bx   [4];
    logic [15:0] by   [4];
    logic        bb   [4];
    logic [18:0] bexp [4];
    logic [8:0]  rdy_tab;
    logic [8:0]  ov_tab;
    int          in_idx;
    int          out_idx;
    logic        accept;

    initial begin
        // Reset with in_valid asserted: it must be ignored
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        X         = 16'h0005;
        Y         = 16'h0003;
        Bin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_ov",   {31'd0, out_valid}, 32'd0);
        chk("rst_D",    {16'd0, D},         32'd0);
        chk("rst_Bout", {31'd0, Bout},      32'd0);
        chk("rst_V",    {31'd0, V},         32'd0);
        chk("rst_Z",    {31'd0, Z},         32'd0);
        chk("rst_rdy",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ov2",  {31'd0, out_valid}, 32'd0);

        // Single vectors, expected {D, Bout, V, Z}
        one_vec("v5m3",   16'h0005, 16'h0003, 1'b0, {16'h0002, 1'b0, 1'b0, 1'b0});
        one_vec("v0m1",   16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0, 1'b0});
        one_vec("vmin",   16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0});
        one_vec("vzero",  16'h1234, 16'h1233, 1'b1, {16'h0000, 1'b0, 1'b0, 1'b1});
        one_vec("vbin",   16'h0000, 16'h0000, 1'b1, {16'hFFFF, 1'b1, 1'b0, 1'b0});
        one_vec("vmax",   16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1, 1'b0});
        one_vec("vffff",  16'hFFFF, 16'hFFFF, 1'b0, {16'h0000, 1'b0, 1'b0, 1'b1});
        one_vec("va5",    16'hA5A5, 16'h5A5A, 1'b0, {16'h4B4B, 1'b0, 1'b1, 1'b0});
        one_vec("vgrp",   16'h1000, 16'h0001, 1'b0, {16'h0FFF, 1'b0, 1'b0, 1'b0});

        // Back-to-back with out_ready low in cycles 3-4
        bx[0] = 16'h0005; by[0] = 16'h0003; bb[0] = 1'b0; bexp[0] = {16'h0002, 3'b000};
        bx[1] = 16'h0000; by[1] = 16'h0001; bb[1] = 1'b0; bexp[1] = {16'hFFFF, 3'b100};
        bx[2] = 16'h8000; by[2] = 16'h0001; bb[2] = 1'b0; bexp[2] = {16'h7FFF, 3'b010};
        bx[3] = 16'h1234; by[3] = 16'h1233; bb[3] = 1'b1; bexp[3] = {16'h0000, 3'b001};
        // bit k-1 is the expected value in cycle k
        rdy_tab = 9'b111110011;
        ov_tab  = 9'b011111100;
        in_idx  = 0;
        out_idx = 0;
        for (int k = 1; k <= 9; k++) begin
            out_ready = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            if (in_idx < 4) begin
                in_valid = 1'b1;
                X        = bx[in_idx];
                Y        = by[in_idx];
                Bin      = bb[in_idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk($sformatf("b2b_rdy_c%0d", k), {31'd0, in_ready},  {31'd0, rdy_tab[k-1]});
            chk($sformatf("b2b_ov_c%0d", k),  {31'd0, out_valid}, {31'd0, ov_tab[k-1]});
            if (out_valid && !out_ready) begin
                if (out_idx < 4)
                    chk($sformatf("b2b_hold_c%0d", k), {13'd0, D, Bout, V, Z}, {13'd0, bexp[out_idx]});
            end
            if (out_valid && out_ready) begin
                if (out_idx < 4)
                    chk($sformatf("b2b_res%0d", out_idx), {13'd0, D, Bout, V, Z}, {13'd0, bexp[out_idx]});
                else
                    chk("b2b_extra", out_idx, 32'd3);
                out_idx++;
            end
            accept = in_valid && in_ready;
            @(posedge clk);
            if (accept) in_idx++;
            @(negedge clk);
        end
        chk("b2b_in_count",  in_idx,  32'd4);
        chk("b2b_out_count", out_idx, 32'd4);

        // Fill both stages with the output stalled, then reset
        in_valid  = 1'b1;
        out_ready = 1'b0;
        X = 16'h0005; Y = 16'h0003; Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        X = 16'h8000; Y = 16'h0001; Bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("full_ov",  {31'd0, out_valid}, 32'd1);
        chk("full_rdy", {31'd0, in_ready},  32'd0);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        X = 16'h1234; Y = 16'h0001; Bin = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mrst_ov",  {31'd0, out_valid}, 32'd0);
        chk("mrst_rdy", {31'd0, in_ready},  32'd1);
        chk("mrst_D",   {16'd0, D},         32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("mrst_stale%0d", k), {31'd0, out_valid}, 32'd0);
        end

        // Pipeline still works after the mid-operation reset
        one_vec("post", 16'h1000, 16'h0001, 1'b0, {16'h0FFF, 1'b0, 1'b0, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
